// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern sequencer (package led_pkg).
// Build option LED_DIM_EN enables PWM dimming.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int PWM_W = 4;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/LED bundle for led_pattern_gen; brightness exists only
// when LED_DIM_EN is defined.
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 4,
    parameter int CNT_W    = 25
);
    import led_pkg::*;

    logic                en;
    logic [1:0]          mode;
    logic [CNT_W-1:0]    period;
    logic                period_load;
    logic [NUM_LEDS-1:0] led;
    logic                step;
`ifdef LED_DIM_EN
    logic [PWM_W-1:0]    brightness;
`endif

    modport master (
`ifdef LED_DIM_EN
        output brightness,
`endif
        output en, mode, period, period_load,
        input  led, step
    );

    modport slave (
`ifdef LED_DIM_EN
        input  brightness,
`endif
        input  en, mode, period, period_load,
        output led, step
    );

endinterface

// File: rtl/led_step_timer.sv
// Programmable period counter; raises step_evt (combinational) in the
// cycle the count reaches period_r-1 while enabled.
module led_step_timer
    import led_pkg::*;
#(
    parameter int          CNT_W      = 25,
    parameter int unsigned DEF_PERIOD = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic             period_load,
    output logic             step_evt
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_r_q, period_r_d;

    // A load wins over counting and swallows any step due that cycle.
    always_comb begin
        cnt_d      = cnt_q;
        period_r_d = period_r_q;
        step_evt   = 1'b0;
        if (period_load) begin
            period_r_d = (period == '0) ? ONE : period;
            cnt_d      = '0;
        end else if (en) begin
            if (cnt_q == period_r_q - ONE) begin
                cnt_d    = '0;
                step_evt = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            period_r_q <= DEF_P;
        end else begin
            cnt_q      <= cnt_d;
            period_r_q <= period_r_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: rotate-left/right, bounce, blink-all.
// Define LED_DIM_EN to add 4-bit PWM brightness on the led output.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int          NUM_LEDS   = 4,
    parameter int          CNT_W      = 25,
    parameter int unsigned DEF_PERIOD = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_gen_if.slave   bus
);

    localparam logic [NUM_LEDS-1:0] ONE_HOT = NUM_LEDS'(1);

    logic                step_evt;
    logic [NUM_LEDS-1:0] led_q, led_d;
    dir_e                dir_q, dir_d;
    mode_e               mode_r_q, mode_r_d;
    mode_e               mode_in;
    logic                step_q, step_d;

    led_step_timer #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .period      (bus.period),
        .period_load (bus.period_load),
        .step_evt    (step_evt)
    );

    // Mode is only looked at on a step; a change restarts from the init pattern.
    always_comb begin
        led_d    = led_q;
        dir_d    = dir_q;
        mode_r_d = mode_r_q;
        step_d   = step_evt;
        mode_in  = mode_e'(bus.mode);
        if (step_evt) begin
            if (mode_in != mode_r_q) begin
                mode_r_d = mode_in;
                dir_d    = DIR_UP;
                led_d    = (mode_in == MODE_BLINK) ? '1 : ONE_HOT;
            end else begin
                case (mode_r_q)
                    MODE_ROT_L:  led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                    MODE_ROT_R:  led_d = {led_q[0], led_q[NUM_LEDS-1:1]};
                    MODE_BOUNCE: begin
                        // Flip direction as the lit bit lands on an end, so each end shows once.
                        if (dir_q == DIR_UP) begin
                            led_d = led_q << 1;
                            if (led_d[NUM_LEDS-1]) dir_d = DIR_DOWN;
                        end else begin
                            led_d = led_q >> 1;
                            if (led_d[0]) dir_d = DIR_UP;
                        end
                    end
                    MODE_BLINK:  led_d = ~led_q;
                    default:     led_d = led_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= ONE_HOT;
            dir_q    <= DIR_UP;
            mode_r_q <= MODE_ROT_L;
            step_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            dir_q    <= dir_d;
            mode_r_q <= mode_r_d;
            step_q   <= step_d;
        end
    end

`ifdef LED_DIM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_d;
    end

    assign bus.led = led_q & {NUM_LEDS{pwm_cnt_q < bus.brightness}};
`else
    assign bus.led = led_q;
`endif

    assign bus.step = step_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern sequencer driving NUM_LEDS outputs from a programmable step period.
- Supports four run-time modes: rotate-left, rotate-right, bounce and blink-all.
- Has a pause control and a one-cycle step strobe.
- Sits at the board-level LED output, fed by static control straps or a small control register.

Parameters:
NUM_LEDS, 4, number of LED outputs; legal range 2..32.
CNT_W, 25, width of period counter and period input.
DEF_PERIOD, 25000000, step period in clk cycles loaded at reset.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  1 = run; 0 = freeze counter and pattern
mode  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 blink-all
period  input  CNT_W  new step period in cycles
period_load  input  1  one-cycle strobe; latch period
led  output  NUM_LEDS  LED drive, registered, 1 = on
step  output  1  one-cycle pulse on every pattern update

Behaviour:
- Reset (sync, rst=1 at clk edge) sets:
  - led = one-hot bit0 (...0001)
  - cnt = 0
  - period_r = DEF_PERIOD
  - dir = up
  - mode_r = 00
  - step = 0
- Period register:
  - period_load=1: period_r <= (period==0 ? 1 : period) and cnt <= 0, regardless of en.
  - period_load has priority over counting in that cycle; no step is issued that cycle.
- Counter:
  - en=1: cnt counts 0..period_r-1 and wraps to 0.
  - The step event occurs in the cycle where cnt == period_r-1.
  - With period_r=1 a step occurs every enabled cycle.
- Step output: registered; step=1 in the cycle after the step event, the same cycle the new led value appears.
- At a step event, if mode != mode_r (mode change):
  - mode_r <= mode.
  - led loads the init pattern instead of advancing: one-hot bit0 for modes 00/01/10, all-ones for 11.
  - dir <= up.
- At a step event with unchanged mode:
  - 00: led <= rotate left by 1; bit N-1 wraps to bit0.
  - 01: led <= rotate right by 1; bit0 wraps to bit N-1.
  - 10: dir=up shifts left; dir=down shifts right. When the new value reaches bit N-1, dir <= down; when it reaches bit0, dir <= up. Endpoints are lit exactly one step each. Sequence for N=4: 0001,0010,0100,1000,0100,0010,0001,0010...
  - 11: led <= ~led (all-on / all-off).
- mode is sampled only at step events; changes between steps have no effect until the next step.
- en=0: cnt, led, dir and mode_r hold; step=0. Resuming continues from the held cnt.
- Reset mid-count or mid-bounce: immediate return to reset values on the next edge.
- Widths:
  - cnt compare uses CNT_W-bit unsigned arithmetic; period_r-1 never underflows because period_r >= 1.
  - Periods wider than CNT_W are not representable.

Optional Feature:
Macro LED_DIM_EN.
- Defined:
  - Adds input brightness[3:0] and a free-running 4-bit pwm_cnt (reset 0, increments every cycle, independent of en).
  - Port led = pattern & {NUM_LEDS{pwm_cnt < brightness}}. brightness=0 gives dark; 15 gives on 15/16 of cycles.
  - The pattern register and step timing are unchanged.
- Not defined: no brightness port, no pwm_cnt; led equals the pattern register directly.

Decomposition:
- Package led_pkg holds:
  - the mode encodings (MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE, MODE_BLINK) as a 2-bit typedef;
  - the dir encoding;
  - the PWM width constant 4.
- Natural sub-module: led_step_timer, containing period_r, cnt, period_load handling, en gating and the step-event output.
- Pattern/mode/dir logic and optional PWM stay in the top.

Test Plan:
- Period 4, mode 00, N=4, en=1 after reset → led 0001→0010→0100→1000→0001, advancing every 4 cycles; step high in each update cycle.
- Period 3, mode 10 → led 0001,0010,0100,1000,0100,0010,0001,0010; dir flips exactly at the 1000 and 0001 endpoints.
- Period 2, mode 01 running, switch to 11 mid-period → next step loads 1111, following steps 0000,1111; switching back to 00 loads 0001.
- period_load=1 with period=0 while cnt=10 → period_r=1, cnt=0, no step that cycle, then a step every cycle.
- en=0 for 7 cycles mid-period (period 5, cnt=2) → led and cnt frozen, step=0; after en=1, the step occurs 2 cycles later. rst=1 mid-bounce returns led=0001, dir up.
- LED_DIM_EN, brightness=4, pattern 0001 → led[0] high for exactly 4 of every 16 cycles; brightness=0 → led all 0.
